// File: rtl/quant_drain_ctrl.sv
// Drains accumulator rows from the systolic array, quantizes each Q16.6 lane to Q4.3,
// and writes the packed rows to out_buffer under valid/ready backpressure.
module quant_drain_ctrl #(
    parameter int NUM_COL   = 16,
    parameter int INPUT_DW  = 23,
    parameter int OUTPUT_DW = 8,
    parameter int ADDR_W    = 10,
    parameter int ROW_W     = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [ROW_W-1:0]             num_rows,
    input  logic [ADDR_W-1:0]            base_addr,
    output logic                         busy,
    output logic                         done,
    output logic [15:0]                  sat_cnt,
    output logic                         acc_rd_en,
    output logic [ROW_W-1:0]             acc_row_idx,
    input  logic [NUM_COL*INPUT_DW-1:0]  acc_rd_data,
    output logic                         ob_wr_en,
    input  logic                         ob_wr_ready,
    output logic [ADDR_W-1:0]            ob_wr_addr,
    output logic [NUM_COL*OUTPUT_DW-1:0] ob_wr_data
);
    localparam int RW    = INPUT_DW - 2;
    localparam int CNT_W = $clog2(NUM_COL + 1);
    localparam logic signed [RW-1:0] Q_MAX = RW'((1 << (OUTPUT_DW - 1)) - 1);
    localparam logic signed [RW-1:0] Q_MIN = RW'(-(1 << (OUTPUT_DW - 1)));

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_next;

    logic [ROW_W-1:0]             rows_q;
    logic [ROW_W-1:0]             rd_cnt;
    logic [ROW_W-1:0]             wr_cnt;
    logic [ADDR_W-1:0]            base_q;
    logic                         in_flight;
    logic                         out_valid;
    logic                         skid_valid;
    logic [NUM_COL*OUTPUT_DW-1:0] out_data;
    logic [NUM_COL*OUTPUT_DW-1:0] skid_data;
    logic [NUM_COL*OUTPUT_DW-1:0] quant_row;
    logic [NUM_COL-1:0][OUTPUT_DW:0] lane_q;
    logic [CNT_W-1:0]             row_sat;
    logic [16:0]                  sat_sum;
    logic [1:0]                   occ;
    logic                         start_ok;
    logic                         accept;
    logic                         last_accept;
    logic                         rows_left;

    // Returns {saturated, value}; the rounding carry gives round-half-away-from-zero.
    function automatic logic [OUTPUT_DW:0] quantize(input logic [INPUT_DW-1:0] x);
        logic signed [RW-1:0] r;
        logic                 c;
        c = x[INPUT_DW-1] ? (x[2] & (x[1] | x[0])) : x[2];
        r = RW'($signed(x) >>> 3) + RW'({1'b0, c});
        if (r > Q_MAX) return {1'b1, Q_MAX[OUTPUT_DW-1:0]};
        if (r < Q_MIN) return {1'b1, Q_MIN[OUTPUT_DW-1:0]};
        return {1'b0, r[OUTPUT_DW-1:0]};
    endfunction

    always_comb begin
        lane_q    = '0;
        quant_row = '0;
        row_sat   = '0;
        for (int i = 0; i < NUM_COL; i++) begin
            lane_q[i] = quantize(acc_rd_data[i*INPUT_DW +: INPUT_DW]);
            quant_row[i*OUTPUT_DW +: OUTPUT_DW] = lane_q[i][OUTPUT_DW-1:0];
            row_sat = row_sat + CNT_W'(lane_q[i][OUTPUT_DW]);
        end
    end

    assign sat_sum     = {1'b0, sat_cnt} + 17'(row_sat);
    assign occ         = {1'b0, out_valid} + {1'b0, skid_valid} + {1'b0, in_flight};
    assign start_ok    = (state == IDLE) && start;
    assign accept      = out_valid && ob_wr_ready;
    assign last_accept = accept && ((wr_cnt + ROW_W'(1)) == rows_q);
    assign rows_left   = (rd_cnt != rows_q);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (num_rows == '0) ? DONE : RUN;
            RUN:     if (last_accept) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A read is only issued when its returning row is guaranteed a slot (output or skid).
    always_comb begin
        busy        = (state == RUN);
        done        = (state == DONE);
        acc_rd_en   = (state == RUN) && rows_left && ((occ - {1'b0, accept}) < 2'd2);
        acc_row_idx = rd_cnt;
        ob_wr_en    = out_valid;
        ob_wr_addr  = base_q + ADDR_W'(wr_cnt);
        ob_wr_data  = out_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rows_q     <= '0;
            base_q     <= '0;
            rd_cnt     <= '0;
            wr_cnt     <= '0;
            sat_cnt    <= '0;
            in_flight  <= 1'b0;
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_data   <= '0;
            skid_data  <= '0;
        end else begin
            if (start_ok) begin
                rows_q  <= num_rows;
                base_q  <= base_addr;
                rd_cnt  <= '0;
                wr_cnt  <= '0;
                sat_cnt <= '0;
            end else begin
                if (acc_rd_en) rd_cnt <= rd_cnt + ROW_W'(1);
                if (accept)    wr_cnt <= wr_cnt + ROW_W'(1);
                if (in_flight) sat_cnt <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
            end
            in_flight <= acc_rd_en;
            // Skid drains ahead of fresh data so rows leave in read order.
            if (accept || !out_valid) begin
                if (skid_valid) begin
                    out_data   <= skid_data;
                    out_valid  <= 1'b1;
                    skid_valid <= in_flight;
                    if (in_flight) skid_data <= quant_row;
                end else begin
                    out_valid <= in_flight;
                    if (in_flight) out_data <= quant_row;
                end
            end else if (in_flight) begin
                skid_valid <= 1'b1;
                skid_data  <= quant_row;
            end
        end
    end
endmodule
